// File: rtl/ddr3_if_pkg.sv
// Shared types and constants for the ddr3_ctrl_model user-interface responder.
package ddr3_if_pkg;

   localparam int unsigned WORD_W      = 16;
   localparam int unsigned BURST_WORDS = 8;
   localparam int unsigned BURST_W     = WORD_W * BURST_WORDS;
   localparam int unsigned LANE_W      = 3;
   localparam int unsigned ADDR_W_DEF  = 26;

   typedef logic [ADDR_W_DEF-1:0] addr_t;
   typedef logic [WORD_W-1:0]     word_t;

   typedef logic [2:0] state_t;
   localparam state_t ST_INIT    = 3'd0;
   localparam state_t ST_IDLE    = 3'd1;
   localparam state_t ST_WRITE   = 3'd2;
   localparam state_t ST_READ    = 3'd3;
   localparam state_t ST_REFRESH = 3'd4;

   // Pick one 16-bit lane out of an 8-word burst.
   function automatic word_t lane_word(input logic [BURST_W-1:0] burst,
                                       input logic [LANE_W-1:0]  lane);
      return burst[{lane, 4'b0000} +: WORD_W];
   endfunction

endpackage

// File: rtl/ddr3_model_mem.sv
// Burst-wide model RAM: 128-bit rows, per-lane 16-bit writes, registered read.
module ddr3_model_mem
   import ddr3_if_pkg::*;
#(
   parameter int unsigned MEM_LOG2 = 12
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         we,
   input  logic [MEM_LOG2-LANE_W-1:0]   waddr,
   input  logic [LANE_W-1:0]            wlane,
   input  word_t                        wdata,
   input  logic                         re,
   input  logic [MEM_LOG2-LANE_W-1:0]   raddr,
   output logic [BURST_W-1:0]           rdata
);

   localparam int unsigned ROWS = 2 ** (MEM_LOG2 - LANE_W);

   logic [BURST_W-1:0] ram [ROWS];

   // Contents survive reset on purpose: committed writes outlive a mid-op reset.
   always_ff @(posedge clk) begin
      if (we) ram[waddr][{wlane, 4'b0000} +: WORD_W] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset)   rdata <= '0;
      else if (re) rdata <= ram[raddr];
   end

endmodule

// File: rtl/ddr3_ctrl_model.sv
// Simulation/loopback stand-in for the ddr3_controller pclk-side user port.
module ddr3_ctrl_model
   import ddr3_if_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 26,
   parameter int unsigned MEM_LOG2    = 12,
   parameter int unsigned INIT_CYCLES = 200,
   parameter int unsigned WR_LATENCY  = 6,
   parameter int unsigned RD_LATENCY  = 12,
   parameter int unsigned REF_LATENCY = 26,
   parameter int unsigned REF_MAX_GAP = 1600,
   parameter logic [7:0]  WSTEP_VAL   = 8'h05,
   parameter logic [1:0]  RCLKPOS_VAL = 2'd1,
   parameter logic [2:0]  RCLKSEL_VAL = 3'd3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  rd,
   input  logic                  wr,
   input  logic                  refresh,
   input  logic [WORD_W-1:0]     din,
   output logic [WORD_W-1:0]     dout,
   output logic [BURST_W-1:0]    dout128,
   output logic                  data_ready,
   output logic                  busy,
   output logic                  write_level_done,
   output logic                  read_calib_done,
   output logic [7:0]            wstep,
   output logic [1:0]            rclkpos,
   output logic [2:0]            rclksel,
   output logic                  proto_err,
   output logic                  refresh_late
);

   localparam int unsigned CNT_W = $clog2(INIT_CYCLES + 256);
   localparam int unsigned GAP_W = $clog2(REF_MAX_GAP + 2);
   localparam int unsigned ROW_W = MEM_LOG2 - LANE_W;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [GAP_W-1:0]   gap, gap_nxt;
   logic [ROW_W-1:0]   rd_row, rd_row_nxt;
   logic [LANE_W-1:0]  rd_lane, rd_lane_nxt;
   logic               busy_nxt, data_ready_nxt, done_nxt, proto_nxt, late_nxt;
   word_t              dout_nxt;
   logic [BURST_W-1:0] dout128_nxt, mem_rdata;
   logic               idle, multi_cmd, any_cmd, acc_ref, acc_wr, acc_rd, mem_re;
   logic               unused_addr_hi;

   assign unused_addr_hi = ^addr[ADDR_WIDTH-1:MEM_LOG2];

   assign idle      = (state == ST_IDLE);
   assign any_cmd   = rd | wr | refresh;
   assign multi_cmd = (2'(rd) + 2'(wr) + 2'(refresh)) > 2'd1;
   assign acc_ref   = idle & refresh;
   assign acc_wr    = idle & wr & ~refresh;
   assign acc_rd    = idle & rd & ~wr & ~refresh;

   ddr3_model_mem #(.MEM_LOG2(MEM_LOG2)) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (acc_wr & ~reset),
      .waddr (addr[MEM_LOG2-1:LANE_W]),
      .wlane (addr[LANE_W-1:0]),
      .wdata (din),
      .re    (mem_re),
      .raddr (rd_row),
      .rdata (mem_rdata)
   );

   // Next-state, counters and outputs.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      busy_nxt       = busy;
      data_ready_nxt = 1'b0;
      dout_nxt       = dout;
      dout128_nxt    = dout128;
      rd_row_nxt     = rd_row;
      rd_lane_nxt    = rd_lane;
      done_nxt       = write_level_done;
      mem_re         = 1'b0;

      case (state)
         ST_INIT: begin
            if (cnt == '0) begin
               state_nxt = ST_IDLE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_IDLE: begin
            if (acc_ref) begin
               state_nxt = ST_REFRESH;
               cnt_nxt   = CNT_W'(REF_LATENCY - 1);
               busy_nxt  = 1'b1;
            end else if (acc_wr) begin
               state_nxt = ST_WRITE;
               cnt_nxt   = CNT_W'(WR_LATENCY - 1);
               busy_nxt  = 1'b1;
            end else if (acc_rd) begin
               state_nxt   = ST_READ;
               cnt_nxt     = CNT_W'(RD_LATENCY - 1);
               busy_nxt    = 1'b1;
               rd_row_nxt  = addr[MEM_LOG2-1:LANE_W];
               rd_lane_nxt = addr[LANE_W-1:0];
            end
         end
         ST_WRITE, ST_REFRESH: begin
            if (cnt == '0) begin
               state_nxt = ST_IDLE;
               busy_nxt  = 1'b0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_READ: begin
            // RAM fetch one cycle ahead of the pulse; busy drops the cycle after it.
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
               mem_re  = (cnt == CNT_W'(1));
            end else if (data_ready) begin
               state_nxt = ST_IDLE;
               busy_nxt  = 1'b0;
            end else begin
               data_ready_nxt = 1'b1;
               dout128_nxt    = mem_rdata;
               dout_nxt       = lane_word(mem_rdata, rd_lane);
            end
         end
         default: begin
            state_nxt = ST_INIT;
            cnt_nxt   = CNT_W'(INIT_CYCLES - 1);
            busy_nxt  = 1'b1;
         end
      endcase

      proto_nxt = proto_err | multi_cmd | (any_cmd & ~idle);

      // Gap counter only runs once out of INIT; a refresh on the boundary wins.
      late_nxt = refresh_late;
      gap_nxt  = gap;
      if (state == ST_INIT) begin
         gap_nxt = '0;
      end else if (acc_ref) begin
         gap_nxt = '0;
      end else if (gap != GAP_W'(REF_MAX_GAP + 1)) begin
         gap_nxt = gap + GAP_W'(1);
         if (gap == GAP_W'(REF_MAX_GAP)) late_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= ST_INIT;
         cnt              <= CNT_W'(INIT_CYCLES - 1);
         gap              <= '0;
         rd_row           <= '0;
         rd_lane          <= '0;
         busy             <= 1'b1;
         data_ready       <= 1'b0;
         dout             <= '0;
         dout128          <= '0;
         write_level_done <= 1'b0;
         read_calib_done  <= 1'b0;
         wstep            <= '0;
         rclkpos          <= '0;
         rclksel          <= '0;
         proto_err        <= 1'b0;
         refresh_late     <= 1'b0;
      end else begin
         state            <= state_nxt;
         cnt              <= cnt_nxt;
         gap              <= gap_nxt;
         rd_row           <= rd_row_nxt;
         rd_lane          <= rd_lane_nxt;
         busy             <= busy_nxt;
         data_ready       <= data_ready_nxt;
         dout             <= dout_nxt;
         dout128          <= dout128_nxt;
         write_level_done <= done_nxt;
         read_calib_done  <= done_nxt;
         wstep            <= done_nxt ? WSTEP_VAL : 8'd0;
         rclkpos          <= done_nxt ? RCLKPOS_VAL : 2'd0;
         rclksel          <= done_nxt ? RCLKSEL_VAL : 3'd0;
         proto_err        <= proto_nxt;
         refresh_late     <= late_nxt;
      end
   end

endmodule

// File: tb/tb_ddr3_ctrl_model.sv
// Directed + random checks of ddr3_ctrl_model against a word-array reference model.
module tb_ddr3_ctrl_model;

   localparam int unsigned AW   = 26;
   localparam int unsigned ML   = 12;
   localparam int unsigned INIT = 200;
   localparam int unsigned WRL  = 6;
   localparam int unsigned RDL  = 12;
   localparam int unsigned REFL = 26;
   localparam int unsigned GAP  = 1600;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] addr = '0;
   logic          rd = 1'b0, wr = 1'b0, refresh = 1'b0;
   logic [15:0]   din = '0;
   logic [15:0]   dout;
   logic [127:0]  dout128;
   logic          data_ready, busy, write_level_done, read_calib_done;
   logic [7:0]    wstep;
   logic [1:0]    rclkpos;
   logic [2:0]    rclksel;
   logic          proto_err, refresh_late;

   int n_asserts = 0;
   int n_fail    = 0;

   // Reference model: only the first 32 words (4 bursts) are ever used, modulo 2^ML.
   logic [15:0] model [32];

   always #5 clk = ~clk;

   ddr3_ctrl_model #(
      .ADDR_WIDTH(AW), .MEM_LOG2(ML), .INIT_CYCLES(INIT), .WR_LATENCY(WRL),
      .RD_LATENCY(RDL), .REF_LATENCY(REFL), .REF_MAX_GAP(GAP),
      .WSTEP_VAL(8'h05), .RCLKPOS_VAL(2'd1), .RCLKSEL_VAL(3'd3)
   ) dut (
      .clk(clk), .reset(reset), .addr(addr), .rd(rd), .wr(wr), .refresh(refresh),
      .din(din), .dout(dout), .dout128(dout128), .data_ready(data_ready), .busy(busy),
      .write_level_done(write_level_done), .read_calib_done(read_calib_done),
      .wstep(wstep), .rclkpos(rclkpos), .rclksel(rclksel),
      .proto_err(proto_err), .refresh_late(refresh_late)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] burst_of(input logic [1:0] row);
      logic [127:0] b;
      for (int i = 0; i < 8; i++) b[16*i +: 16] = model[{row, 3'(i)}];
      return b;
   endfunction

   // Random upper bits (aliased away by the DUT) over a word index in the model window.
   function automatic logic [AW-1:0] alias_addr(input logic [4:0] idx);
      logic [AW-1:0] a;
      a = AW'($urandom);
      a[ML-1:0] = {7'd0, idx};
      return a;
   endfunction

   task automatic do_reset_init();
      int n;
      int dr_seen;
      rd = 1'b0; wr = 1'b0; refresh = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      check("rst_busy", 128'(busy), 128'(1));
      check("rst_dr_dout", {data_ready, dout, dout128}, '0);
      check("rst_status", {write_level_done, read_calib_done, wstep, rclkpos, rclksel}, '0);
      check("rst_sticky", {proto_err, refresh_late}, '0);
      reset = 1'b0;
      n = 0;
      dr_seen = 0;
      while (busy === 1'b1 && n < int'(INIT) + 50) begin
         tick();
         n++;
         if (data_ready === 1'b1) dr_seen++;
      end
      check("init_len", 128'(n), 128'(INIT));
      check("init_no_dr", 128'(dr_seen), 128'(0));
      check("init_status", {write_level_done, read_calib_done, wstep, rclkpos, rclksel},
            {1'b1, 1'b1, 8'h05, 2'd1, 3'd3});
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [15:0] d);
      int n;
      wr = 1'b1; addr = a; din = d;
      tick();
      wr = 1'b0;
      model[a[4:0]] = d;
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         tick();
         n++;
      end
      check("wr_busy_len", 128'(n), 128'(WRL));
   endtask

   task automatic do_refresh();
      int n;
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         tick();
         n++;
      end
      check("ref_busy_len", 128'(n), 128'(REFL));
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      int k, dr_k, pulses;
      logic [15:0]  exp16;
      logic [127:0] exp128;
      exp16  = model[a[4:0]];
      exp128 = burst_of(a[4:3]);
      rd = 1'b1; addr = a;
      tick();
      rd = 1'b0;
      check("rd_busy", 128'(busy), 128'(1));
      k = 0; dr_k = -1; pulses = 0;
      while (busy === 1'b1 && k < int'(RDL) + 50) begin
         tick();
         k++;
         if (data_ready === 1'b1) begin
            pulses++;
            if (dr_k < 0) begin
               dr_k = k;
               check("rd_dout", 128'(dout), 128'(exp16));
               check("rd_dout128", dout128, exp128);
            end
         end
      end
      check("rd_latency", 128'(dr_k), 128'(RDL));
      check("rd_busy_fall", 128'(k), 128'(RDL + 1));
      check("rd_pulses", 128'(pulses), 128'(1));
      check("rd_dout_hold", 128'(dout), 128'(exp16));
   endtask

   initial begin
      int n, dr_seen, op;
      logic [4:0] idx;

      do_reset_init();

      // Fill the whole model window so every burst read is fully defined.
      for (int i = 0; i < 32; i++) do_write(alias_addr(5'(i)), 16'($urandom));

      do_write(26'd2, 16'h5566);
      do_read(26'd2);
      check("dir_5566", 128'(dout), 128'h5566);
      check("dir_5566_lane", 128'(dout128[47:32]), 128'h5566);

      do_write(26'd0, 16'h1122);
      do_write(26'd1, 16'h3344);
      do_read(26'd4096);
      check("alias_dout", 128'(dout), 128'h1122);
      check("alias_lo32", 128'(dout128[31:0]), 128'h33441122);

      for (int i = 0; i < 40; i++) begin
         op  = int'($urandom_range(0, 2));
         idx = 5'($urandom);
         if (op == 0)      do_write(alias_addr(idx), 16'($urandom));
         else if (op == 1) do_read(alias_addr(idx));
         else              do_refresh();
      end
      check("rand_no_proto", 128'(proto_err), 128'(0));

      // Write dropped while a read is in flight.
      rd = 1'b1; addr = 26'd5;
      tick();
      rd = 1'b0;
      tick();
      tick();
      wr = 1'b1; addr = 26'd6; din = ~model[6];
      tick();
      wr = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         tick();
         n++;
      end
      check("drop_wr_proto", 128'(proto_err), 128'(1));
      do_read(26'd6);

      // rd+wr together: write wins, no read data, protocol flagged.
      do_reset_init();
      rd = 1'b1; wr = 1'b1; addr = 26'd9; din = 16'hBEEF;
      tick();
      rd = 1'b0; wr = 1'b0;
      model[9] = 16'hBEEF;
      n = 0; dr_seen = 0;
      while (busy === 1'b1 && n < 300) begin
         tick();
         n++;
         if (data_ready === 1'b1) dr_seen++;
      end
      check("rdwr_busy_len", 128'(n), 128'(WRL));
      check("rdwr_no_dr", 128'(dr_seen), 128'(0));
      check("rdwr_proto", 128'(proto_err), 128'(1));
      do_read(26'd9);

      // Refresh gap exceeded.
      do_reset_init();
      repeat (GAP) tick();
      check("gap_at_max", 128'(refresh_late), 128'(0));
      tick();
      check("gap_over", 128'(refresh_late), 128'(1));

      // Refresh on the boundary cycle wins, then periodic refresh keeps it clear.
      do_reset_init();
      repeat (GAP) tick();
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
      check("gap_boundary", 128'(refresh_late), 128'(0));
      repeat (780) tick();
      for (int i = 0; i < 13; i++) begin
         refresh = 1'b1;
         tick();
         refresh = 1'b0;
         repeat (780) tick();
      end
      check("periodic_late", 128'(refresh_late), 128'(0));
      check("periodic_proto", 128'(proto_err), 128'(0));

      // Reset in the middle of a read.
      rd = 1'b1; addr = 26'd2;
      tick();
      rd = 1'b0;
      dr_seen = 0;
      repeat (4) begin
         tick();
         if (data_ready === 1'b1) dr_seen++;
      end
      do_reset_init();
      check("midrd_no_dr", 128'(dr_seen), 128'(0));
      do_read(26'd2);
      do_read(26'd9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr3_ctrl_model.md
Name: ddr3_ctrl_model

Overview:
- Synthesizable responder for the pclk-side user interface of ddr3_controller: rd/wr/refresh/addr/din in; dout/dout128/data_ready/busy and calibration status out.
- Backed by a small on-chip RAM with programmable latencies.
- Replaces the real controller in simulation and in FPGA loopback builds, so test FSMs (WIPE/WRITE_BLOCK/VERIFY_BLOCK style) can be checked without DDR3 silicon.
- Also polices the initiator: flags protocol violations and late refreshes.

Parameters:
- ADDR_WIDTH, 26: user address width, in 16-bit words.
- MEM_LOG2, 12: log2 of model RAM depth in 16-bit words; upper address bits alias.
- INIT_CYCLES, 200: busy cycles after reset before calibration done.
- WR_LATENCY, 6: busy cycles per write, range 1..255.
- RD_LATENCY, 12: cycles from rd accept to data_ready, range 2..255.
- REF_LATENCY, 26: busy cycles per refresh (tRFC stand-in), range 1..255.
- REF_MAX_GAP, 1600: maximum allowed cycles between refreshes after init.
- WSTEP_VAL, 8'h05: reported wstep.
- RCLKPOS_VAL, 2'd1: reported rclkpos.
- RCLKSEL_VAL, 3'd3: reported rclksel.

Ports:
- clk  in  1: single clock, pclk domain.
- reset  in  1: synchronous, active-high.
- addr  in  ADDR_WIDTH: word address, sampled with rd/wr.
- rd  in  1: one-cycle read request.
- wr  in  1: one-cycle write request.
- refresh  in  1: one-cycle refresh request.
- din  in  16: write data, sampled with wr.
- dout  out  16: read word, valid with data_ready.
- dout128  out  128: aligned 8-word burst containing addr; word i at [16i+15:16i].
- data_ready  out  1: one-cycle pulse per accepted read.
- busy  out  1: command in progress or init not done.
- write_level_done  out  1: high once init completes.
- read_calib_done  out  1: high once init completes.
- wstep  out  8: WSTEP_VAL after init, else 0.
- rclkpos  out  2: RCLKPOS_VAL after init, else 0.
- rclksel  out  3: RCLKSEL_VAL after init, else 0.
- proto_err  out  1: sticky; command while busy, or more than one command in a cycle.
- refresh_late  out  1: sticky; refresh gap exceeded REF_MAX_GAP.

Behaviour:
- Reset values:
  - busy=1; data_ready=0; dout=0; dout128=0.
  - Status outputs: 0.
  - proto_err=0; refresh_late=0.
  - State=INIT.
- All outputs are registered. RAM contents are not cleared by reset and are undefined at power-up.
- States: INIT, IDLE, WRITE, READ, REFRESH.
- INIT:
  - Count INIT_CYCLES.
  - Then set write_level_done, read_calib_done and the status values; busy=0; go to IDLE.
  - Commands received in INIT are ignored and set proto_err.
- IDLE, command accept (command sampled on edge E):
  - busy=1 is visible from the cycle after E.
  - Priority when several are high: refresh > wr > rd; proto_err is set.
- WRITE:
  - RAM word addr[MEM_LOG2-1:0] <= din at E.
  - busy is held for exactly WR_LATENCY cycles, then IDLE.
- READ:
  - Address is latched at E.
  - data_ready pulses in cycle E+RD_LATENCY with dout and dout128.
  - busy falls one cycle after the data_ready pulse, so the initiator always sees data_ready while busy=1.
  - dout/dout128 hold until the next read completes.
- REFRESH:
  - busy is held for REF_LATENCY cycles. The RAM is untouched.
  - Clears the gap counter.
- Commands arriving while busy=1 are dropped (no RAM effect) and set proto_err.
- Gap counter:
  - Runs from leaving INIT and saturates at REF_MAX_GAP+1.
  - refresh_late is set when the counter reaches REF_MAX_GAP+1.
  - A refresh accepted in the same cycle the counter reaches REF_MAX_GAP+1 wins: no flag, counter clears.
- Read-after-write to the same address returns the new data. The write completes before busy drops, so there is no bypass path needed.
- Address wrap: addr bits above MEM_LOG2 are ignored. Address 2^MEM_LOG2 aliases to 0.
- Reset mid-operation:
  - Aborts the operation; no data_ready pulse is issued.
  - A write accepted before reset stays committed.
  - Block re-enters INIT.

Decomposition:
- Package ddr3_if_pkg holds:
  - State enum.
  - Localparams for user word width (16) and burst words (8).
  - Typedefs ADDR (ADDR_WIDTH-bit) and WORD (16-bit).
- Sub-module ddr3_model_mem: 2^(MEM_LOG2-3) x 128-bit RAM.
  - 16-bit lane write enable selected by addr[2:0].
  - Single registered read port.
  - Gives dout128 directly; dout is a lane mux on it.

Test Plan:
- Init: release reset with INIT_CYCLES=200 -> busy=1 for 200 cycles, then write_level_done=read_calib_done=1, wstep=8'h05, rclkpos=1, rclksel=3, busy=0.
- Single write then read:
  - wr addr=2, din=16'h5566 -> busy for 6 cycles.
  - Then rd addr=2 -> data_ready exactly 12 cycles after accept, dout=16'h5566, dout128[47:32]=16'h5566.
  - busy falls one cycle later.
- Burst and alias:
  - Write 16'h1122, 16'h3344 to addrs 0 and 1.
  - Read addr 4096 (MEM_LOG2=12) -> dout=16'h1122, dout128[31:0]=32'h33441122.
- Protocol checks:
  - wr during a read's busy window -> RAM unchanged, proto_err=1.
  - rd+wr in the same cycle -> write performed, proto_err=1.
- Refresh gap:
  - No refresh for 1601 cycles after init -> refresh_late=1.
  - After reset, refresh every 781 cycles for 10k cycles -> refresh_late stays 0.
- Reset mid-read: assert reset at cycle 5 of a read -> no data_ready pulse, busy=1, INIT restarts, earlier written data is still readable afterwards.
